// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predictor and its BTB.
package branch_pkg;

  // 2-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // Fall-through redirect skips the branch and its delay slot.
  localparam int unsigned DELAY_SLOT_OFFSET = 8;

  // Move the counter one step toward the resolved outcome, saturating at the ends.
  function automatic bp_ctr_t sat_update(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = bp_ctr_t'(2'(ctr + 2'd1));
    end else begin
      if (ctr != SNT) res = bp_ctr_t'(2'(ctr - 2'd1));
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_btb.sv
// Direct-mapped branch target buffer.
// Ports: clk/rst_n (sync clear of valid bits and counters); rd_* async lookup
// (hit, counter, target, all zero on a miss); wr_* resolved-branch update
// applied at the clock edge (counter update on hit, allocate on taken miss).
module branch_btb
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_pc,
  output logic              rd_hit_c,
  output bp_ctr_t           rd_ctr_c,
  output logic [ADDR_W-1:0] rd_target_c,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic              wr_taken,
  input  logic              wr_is_jump,
  input  logic [ADDR_W-1:0] wr_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  bp_ctr_t            ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit_c;

  // Instruction words are aligned, so the byte offset carries no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[ADDR_W-1:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[ADDR_W-1:IDX_W+2];

  // Lookup sees the pre-update contents when read and write share an index.
  always_comb begin
    rd_hit_c    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_ctr_c    = rd_hit_c ? ctr_q[rd_idx] : SNT;
    rd_target_c = rd_hit_c ? target_q[rd_idx] : '0;
    wr_hit_c    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  // Valid bits and counters: cleared by reset, which also blocks any update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= SNT;
    end else if (wr_en) begin
      if (wr_hit_c) begin
        ctr_q[wr_idx] <= sat_update(ctr_q[wr_idx], wr_taken);
      end else if (wr_taken) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= wr_is_jump ? ST : WT;
      end
    end
  end

  // Tag/target payload needs no reset; only taken resolves write it.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en && wr_taken) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor and resolver.
// Ports: Clock/nReset (sync, active-low); FetchPC -> PredTaken/PredPC
// (combinational BTB lookup); Res* resolved branch from EX; Mispredict/
// CorrectPC registered redirect; BranchCount/MissCount saturating statistics.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [ADDR_W-1:0] FetchPC,
  output logic              PredTaken,
  output logic [ADDR_W-1:0] PredPC,
  input  logic              ResValid,
  input  logic [ADDR_W-1:0] ResPC,
  input  logic              ResTaken,
  input  logic [ADDR_W-1:0] ResTarget,
  input  logic              ResIsJump,
  input  logic              ResPredTaken,
  input  logic [ADDR_W-1:0] ResPredPC,
  output logic              Mispredict,
  output logic [ADDR_W-1:0] CorrectPC,
  output logic [STAT_W-1:0] BranchCount,
  output logic [STAT_W-1:0] MissCount
);

  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              btb_hit_c;
  bp_ctr_t           btb_ctr_c;
  logic [ADDR_W-1:0] btb_target_c;
  logic              wrong_c;
  logic [ADDR_W-1:0] correct_pc_c;

  branch_btb #(
    .ADDR_W (ADDR_W),
    .ENTRIES(ENTRIES)
  ) u_btb (
    .clk        (Clock),
    .rst_n      (nReset),
    .rd_pc      (FetchPC),
    .rd_hit_c   (btb_hit_c),
    .rd_ctr_c   (btb_ctr_c),
    .rd_target_c(btb_target_c),
    .wr_en      (ResValid),
    .wr_pc      (ResPC),
    .wr_taken   (ResTaken),
    .wr_is_jump (ResIsJump),
    .wr_target  (ResTarget)
  );

  // Fetch-side prediction; target is zeroed unless predicting taken.
  always_comb begin
    PredTaken = btb_hit_c && ((btb_ctr_c == WT) || (btb_ctr_c == ST));
    PredPC    = PredTaken ? btb_target_c : '0;
  end

  // Direction or target disagreement with what fetch assumed.
  always_comb begin
    wrong_c      = ResValid && ((ResTaken != ResPredTaken) ||
                                (ResTaken && (ResTarget != ResPredPC)));
    correct_pc_c = ResTaken ? ResTarget : ResPC + ADDR_W'(DELAY_SLOT_OFFSET);
  end

  // Redirect pulse, held redirect address and saturating statistics.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      Mispredict  <= 1'b0;
      CorrectPC   <= '0;
      BranchCount <= '0;
      MissCount   <= '0;
    end else begin
      Mispredict <= wrong_c;
      if (wrong_c) CorrectPC <= correct_pc_c;
      if (ResValid && (BranchCount != STAT_MAX)) BranchCount <= BranchCount + STAT_W'(1);
      if (wrong_c && (MissCount != STAT_MAX)) MissCount <= MissCount + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: hand-derived vector table, corner sequences and a
// randomized run compared against an array-based predictor model.
module tb_branch_predictor;

  localparam int ENT = 64;

  logic        Clock;
  logic        nReset;
  logic [31:0] FetchPC;
  logic        ResValid, ResTaken, ResIsJump, ResPredTaken;
  logic [31:0] ResPC, ResTarget, ResPredPC;
  logic        PredTaken, Mispredict;
  logic [31:0] PredPC, CorrectPC, BranchCount, MissCount;
  logic        PredTaken4, Mispredict4;
  logic [31:0] PredPC4, CorrectPC4;
  logic [3:0]  BranchCount4, MissCount4;

  branch_predictor #(.ADDR_W(32), .ENTRIES(64), .STAT_W(32)) dut (
    .Clock(Clock), .nReset(nReset), .FetchPC(FetchPC),
    .PredTaken(PredTaken), .PredPC(PredPC),
    .ResValid(ResValid), .ResPC(ResPC), .ResTaken(ResTaken), .ResTarget(ResTarget),
    .ResIsJump(ResIsJump), .ResPredTaken(ResPredTaken), .ResPredPC(ResPredPC),
    .Mispredict(Mispredict), .CorrectPC(CorrectPC),
    .BranchCount(BranchCount), .MissCount(MissCount)
  );

  branch_predictor #(.ADDR_W(32), .ENTRIES(64), .STAT_W(4)) dut4 (
    .Clock(Clock), .nReset(nReset), .FetchPC(FetchPC),
    .PredTaken(PredTaken4), .PredPC(PredPC4),
    .ResValid(ResValid), .ResPC(ResPC), .ResTaken(ResTaken), .ResTarget(ResTarget),
    .ResIsJump(ResIsJump), .ResPredTaken(ResPredTaken), .ResPredPC(ResPredPC),
    .Mispredict(Mispredict4), .CorrectPC(CorrectPC4),
    .BranchCount(BranchCount4), .MissCount(MissCount4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        rst_n;
    logic [31:0] fetch;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        rj;
    logic        rpt;
    logic [31:0] rppc;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        ept;
    logic [31:0] eppc;
    logic        emisp;
    logic [31:0] ecpc;
    logic [31:0] ebc;
    logic [31:0] emc;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: one record per BTB slot, counter held as an integer 0..3.
  bit          m_valid  [ENT];
  logic [31:0] m_tag    [ENT];
  logic [31:0] m_target [ENT];
  int          m_ctr    [ENT];
  bit          m_misp;
  logic [31:0] m_cpc;
  longint      m_bc, m_mc;
  bit          m_known = 0;

  logic        pt_s;
  logic [31:0] ppc_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(ENT));
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] ppc);
    int s;
    s   = slot(pc);
    pt  = m_valid[s] && (m_tag[s] == (pc >> 8)) && (m_ctr[s] >= 2);
    ppc = pt ? m_target[s] : 32'h0;
  endfunction

  function automatic void m_step(input in_t i);
    bit wrong;
    int s;
    if (!i.rst_n) begin
      for (int k = 0; k < ENT; k++) begin
        m_valid[k] = 0;
        m_ctr[k]   = 0;
      end
      m_misp  = 0;
      m_cpc   = 32'h0;
      m_bc    = 0;
      m_mc    = 0;
      m_known = 1;
      return;
    end
    wrong  = i.rv && ((i.rt != i.rpt) || (i.rt && (i.rtgt != i.rppc)));
    m_misp = wrong;
    if (wrong) m_cpc = i.rt ? i.rtgt : i.rpc + 32'd8;
    if (i.rv) m_bc++;
    if (wrong) m_mc++;
    if (i.rv) begin
      s = slot(i.rpc);
      if (m_valid[s] && (m_tag[s] == (i.rpc >> 8))) begin
        m_ctr[s] = i.rt ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1) : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
        if (i.rt) m_target[s] = i.rtgt;
      end else if (i.rt) begin
        m_valid[s]  = 1;
        m_tag[s]    = i.rpc >> 8;
        m_target[s] = i.rtgt;
        m_ctr[s]    = i.rj ? 3 : 2;
      end
    end
  endfunction

  // One clock: drive at negedge, check lookup before the edge, registers after it.
  task automatic run_cycle(input in_t i);
    logic        ept;
    logic [31:0] eppc;
    longint      sat4_bc, sat4_mc;
    @(negedge Clock);
    nReset = i.rst_n; FetchPC = i.fetch; ResValid = i.rv; ResPC = i.rpc;
    ResTaken = i.rt; ResTarget = i.rtgt; ResIsJump = i.rj;
    ResPredTaken = i.rpt; ResPredPC = i.rppc;
    #1;
    pt_s  = PredTaken;
    ppc_s = PredPC;
    if (m_known) begin
      m_lookup(i.fetch, ept, eppc);
      check("model_pred_taken", {63'h0, PredTaken}, {63'h0, ept});
      check("model_pred_pc", {32'h0, PredPC}, {32'h0, eppc});
      check("model_pred_taken_s4", {63'h0, PredTaken4}, {63'h0, ept});
    end
    @(posedge Clock);
    m_step(i);
    #1;
    sat4_bc = (m_bc > 15) ? 15 : m_bc;
    sat4_mc = (m_mc > 15) ? 15 : m_mc;
    check("model_mispredict", {63'h0, Mispredict}, {63'h0, m_misp});
    check("model_correct_pc", {32'h0, CorrectPC}, {32'h0, m_cpc});
    check("model_branch_count", {32'h0, BranchCount}, 64'(m_bc));
    check("model_miss_count", {32'h0, MissCount}, 64'(m_mc));
    check("model_branch_count_s4", {60'h0, BranchCount4}, 64'(sat4_bc));
    check("model_miss_count_s4", {60'h0, MissCount4}, 64'(sat4_mc));
  endtask

  function automatic in_t mk_in(input logic rst_n, input logic [31:0] fetch, input logic rv,
                                input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                                input logic rj, input logic rpt, input logic [31:0] rppc);
    in_t r;
    r.rst_n = rst_n; r.fetch = fetch; r.rv = rv; r.rpc = rpc; r.rt = rt;
    r.rtgt = rtgt; r.rj = rj; r.rpt = rpt; r.rppc = rppc;
    return r;
  endfunction

  function automatic vec_t mk(input in_t in, input logic ept, input logic [31:0] eppc,
                              input logic emisp, input logic [31:0] ecpc,
                              input logic [31:0] ebc, input logic [31:0] emc);
    vec_t v;
    v.in = in; v.ept = ept; v.eppc = eppc; v.emisp = emisp;
    v.ecpc = ecpc; v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] bases [4];
    bases[0] = 32'h0040_0000; bases[1] = 32'h0041_0000;
    bases[2] = 32'h1234_5600; bases[3] = 32'hFFFF_FFC0;
    return bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 63));
  endfunction

  localparam logic [31:0] A  = 32'h0040_0010;
  localparam logic [31:0] TA = 32'h0040_0100;
  localparam logic [31:0] B  = 32'h0041_0010;
  localparam logic [31:0] TB = 32'h0041_0200;
  localparam logic [31:0] J  = 32'hFFFF_FFF8;
  localparam logic [31:0] TJ = 32'h0040_0000;

  vec_t tbl [13];

  initial begin
    in_t ri;
    logic        lpt;
    logic [31:0] lppc;

    nReset = 1'b0; FetchPC = '0; ResValid = 1'b0; ResPC = '0; ResTaken = 1'b0;
    ResTarget = '0; ResIsJump = 1'b0; ResPredTaken = 1'b0; ResPredPC = '0;

    tbl[0]  = mk(mk_in(1, A, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(mk_in(1, A, 1, A, 1, TA, 0, 0, 0), 0, 0, 1, TA, 1, 1);
    tbl[2]  = mk(mk_in(1, A, 0, 0, 0, 0, 0, 0, 0), 1, TA, 0, TA, 1, 1);
    tbl[3]  = mk(mk_in(1, A, 1, A, 0, A + 8, 0, 1, TA), 1, TA, 1, 32'h0040_0018, 2, 2);
    tbl[4]  = mk(mk_in(1, A, 1, A, 0, A + 8, 0, 1, TA), 0, 0, 1, 32'h0040_0018, 3, 3);
    tbl[5]  = mk(mk_in(1, A, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 32'h0040_0018, 3, 3);
    tbl[6]  = mk(mk_in(1, A, 1, A, 1, TA, 0, 0, 0), 0, 0, 1, TA, 4, 4);
    tbl[7]  = mk(mk_in(1, A, 1, B, 1, TB, 0, 0, 0), 0, 0, 1, TB, 5, 5);
    tbl[8]  = mk(mk_in(1, A, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, TB, 5, 5);
    tbl[9]  = mk(mk_in(1, B, 0, 0, 0, 0, 0, 0, 0), 1, TB, 0, TB, 5, 5);
    tbl[10] = mk(mk_in(1, J, 1, J, 1, TJ, 1, 1, TJ), 0, 0, 0, TB, 6, 5);
    tbl[11] = mk(mk_in(1, J, 1, J, 0, 0, 0, 1, TJ), 1, TJ, 1, 32'h0000_0000, 7, 6);
    tbl[12] = mk(mk_in(1, J, 0, 0, 0, 0, 0, 0, 0), 1, TJ, 0, 32'h0000_0000, 7, 6);

    run_cycle(mk_in(0, A, 0, 0, 0, 0, 0, 0, 0));
    run_cycle(mk_in(0, A, 0, 0, 0, 0, 0, 0, 0));
    check("reset_mispredict", {63'h0, Mispredict}, 64'h0);
    check("reset_branch_count", {32'h0, BranchCount}, 64'h0);
    check("reset_miss_count", {32'h0, MissCount}, 64'h0);

    for (int k = 0; k < 13; k++) begin
      run_cycle(tbl[k].in);
      check($sformatf("vec%0d_pred_taken", k), {63'h0, pt_s}, {63'h0, tbl[k].ept});
      check($sformatf("vec%0d_pred_pc", k), {32'h0, ppc_s}, {32'h0, tbl[k].eppc});
      check($sformatf("vec%0d_mispredict", k), {63'h0, Mispredict}, {63'h0, tbl[k].emisp});
      check($sformatf("vec%0d_correct_pc", k), {32'h0, CorrectPC}, {32'h0, tbl[k].ecpc});
      check($sformatf("vec%0d_branch_count", k), {32'h0, BranchCount}, {32'h0, tbl[k].ebc});
      check($sformatf("vec%0d_miss_count", k), {32'h0, MissCount}, {32'h0, tbl[k].emc});
    end

    // Counter saturation: 20 wrong resolves after a clean reset.
    run_cycle(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 20; k++)
      run_cycle(mk_in(1, 32'h0050_0000, 1, 32'h0050_0000, 0, 0, 0, 1, 32'h0050_1000));
    check("sat_branch_count_s4", {60'h0, BranchCount4}, 64'd15);
    check("sat_miss_count_s4", {60'h0, MissCount4}, 64'd15);
    check("sat_branch_count_s32", {32'h0, BranchCount}, 64'd20);
    check("sat_miss_pulse_held", {63'h0, Mispredict}, 64'h1);

    // Reset coinciding with a taken resolve: reset wins, BTB emptied.
    run_cycle(mk_in(1, 0, 1, 32'h0060_0020, 1, 32'h0060_0800, 0, 0, 0));
    run_cycle(mk_in(0, 0, 1, 32'h0060_0040, 1, 32'h0060_0900, 0, 0, 0));
    check("rstres_mispredict", {63'h0, Mispredict}, 64'h0);
    check("rstres_correct_pc", {32'h0, CorrectPC}, 64'h0);
    check("rstres_branch_count", {32'h0, BranchCount}, 64'h0);
    check("rstres_miss_count_s4", {60'h0, MissCount4}, 64'h0);
    run_cycle(mk_in(1, 32'h0060_0020, 0, 0, 0, 0, 0, 0, 0));
    check("rstres_old_entry_gone", {63'h0, pt_s}, 64'h0);
    run_cycle(mk_in(1, 32'h0060_0040, 0, 0, 0, 0, 0, 0, 0));
    check("rstres_no_write", {63'h0, pt_s}, 64'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      ri.rst_n = ($urandom_range(0, 199) != 0);
      ri.rv    = ($urandom_range(0, 3) != 0);
      ri.rpc   = rand_pc();
      ri.rj    = ($urandom_range(0, 4) == 0);
      ri.rt    = ri.rj || ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       ri.rtgt = 32'h0040_0100;
        1:       ri.rtgt = 32'h0041_0200;
        default: ri.rtgt = rand_pc();
      endcase
      m_lookup(ri.rpc, lpt, lppc);
      if ($urandom_range(0, 3) != 0) begin
        ri.rpt  = lpt;
        ri.rppc = lppc;
      end else begin
        ri.rpt  = 1'($urandom_range(0, 1));
        ri.rppc = ($urandom_range(0, 1) == 1) ? ri.rtgt : rand_pc();
      end
      ri.fetch = ($urandom_range(0, 1) == 1) ? ri.rpc : rand_pc();
      run_cycle(ri);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
